// File: rtl/wide_alu_seq.sv
// Registered block-field ALU: extracts block-aligned fields from two wide words, operates, writes back into in1's field.
// Optional shift-add multiplier enabled by defining WIDE_ALU_MUL_EN; otherwise opcode 8 acts as a reserved code.
module wide_alu_seq #(
    parameter int unsigned BLOCK_W = 16,
    parameter int unsigned BLOCKS  = 32,
    parameter int unsigned SEL_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [3:0]                 operation,
    input  logic [BLOCK_W*BLOCKS-1:0]  in1,
    input  logic [BLOCK_W*BLOCKS-1:0]  in2,
    input  logic                       carry_in,
    input  logic [SEL_W-1:0]           op_size,
    input  logic [SEL_W-1:0]           op_offset1,
    input  logic [SEL_W-1:0]           op_offset2,
    input  logic                       sign_extend,
    output logic [BLOCK_W*BLOCKS-1:0]  res,
    output logic                       carry,
    output logic                       zero,
    output logic                       ready,
    output logic                       done
);

    localparam int unsigned W     = BLOCK_W * BLOCKS;
    localparam int unsigned IDX_W = $clog2(W) + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_LD  = 4'd7;
    localparam logic [3:0] OP_RSH = 4'd9;
    localparam logic [3:0] OP_LSH = 4'd10;
    localparam logic [3:0] OP_ASR = 4'd11;
    localparam logic [3:0] OP_LSC = 4'd12;
    localparam logic [3:0] OP_RSC = 4'd13;
`ifdef WIDE_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd8;
`endif

    // Bit count of nblk blocks.
    function automatic logic [IDX_W-1:0] blk_bits(input logic [SEL_W:0] nblk);
        return IDX_W'(nblk) * IDX_W'(BLOCK_W);
    endfunction

    // Ones over the low (size+1) blocks.
    function automatic logic [W-1:0] low_mask(input logic [SEL_W-1:0] size);
        logic [W-1:0] m;
        m = '0;
        for (int b = 0; b < int'(BLOCKS); b++) begin
            if (b <= int'(size)) m[b*BLOCK_W +: BLOCK_W] = '1;
        end
        return m;
    endfunction

    // Ones over blocks strictly above the written field.
    function automatic logic [W-1:0] ext_mask(input logic [SEL_W-1:0] off, input logic [SEL_W-1:0] size);
        logic [W-1:0] m;
        m = '0;
        for (int b = 0; b < int'(BLOCKS); b++) begin
            if (b > int'(off) + int'(size)) m[b*BLOCK_W +: BLOCK_W] = '1;
        end
        return m;
    endfunction

    // Returns {zero, word}: result field placed at off, optional sign fill above it.
    function automatic logic [W:0] write_back(input logic [W-1:0] base, input logic [W-1:0] result,
                                              input logic [SEL_W-1:0] off, input logic [SEL_W-1:0] size,
                                              input logic se);
        logic [IDX_W-1:0] sh;
        logic [IDX_W-1:0] top;
        logic [W-1:0]     pm;
        logic [W-1:0]     placed;
        logic [W-1:0]     r;
        logic [W-1:0]     em;
        logic [W-1:0]     res_sh;
        sh     = blk_bits((SEL_W+1)'(off));
        top    = blk_bits((SEL_W+1)'(size) + (SEL_W+1)'(1)) - IDX_W'(1);
        pm     = low_mask(size) << sh;
        placed = (result << sh) & pm;
        r      = (base & ~pm) | placed;
        em     = ext_mask(off, size);
        res_sh = result >> top;
        if (se) r = (r & ~em) | ({W{res_sh[0]}} & em);
        return {(placed == '0), r};
    endfunction

    logic [W-1:0]     fmask;
    logic [IDX_W-1:0] fw_bits;
    logic [W-1:0]     top_one;
    logic [W-1:0]     arg1;
    logic [W-1:0]     arg2;
    logic             msb2;
    logic [W-1:0]     addend;
    logic             cin;
    logic [W:0]       sum;
    logic [W-1:0]     alu_res;
    logic             alu_carry;
    logic [W:0]       wb_now;

    // Single-cycle datapath on the live inputs.
    always_comb begin
        fmask     = low_mask(op_size);
        fw_bits   = blk_bits((SEL_W+1)'(op_size) + (SEL_W+1)'(1));
        top_one   = W'(1) << (fw_bits - IDX_W'(1));
        arg1      = (in1 >> blk_bits((SEL_W+1)'(op_offset1))) & fmask;
        arg2      = (in2 >> blk_bits((SEL_W+1)'(op_offset2))) & fmask;
        msb2      = |(arg2 & top_one);
        addend    = '0;
        cin       = 1'b0;
        sum       = '0;
        alu_res   = arg1;
        alu_carry = carry_in;
        case (operation)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                addend    = (operation == OP_SUB || operation == OP_SBC) ? (~arg2 & fmask) : arg2;
                cin       = (operation == OP_SUB) ? 1'b1 : (operation == OP_ADD) ? 1'b0 : carry_in;
                sum       = {1'b0, arg1} + {1'b0, addend} + (W+1)'(cin);
                alu_res   = sum[W-1:0] & fmask;
                alu_carry = |(sum & ((W+1)'(1) << fw_bits));
            end
            OP_AND: alu_res = arg1 & arg2;
            OP_OR:  alu_res = arg1 | arg2;
            OP_XOR: alu_res = arg1 ^ arg2;
            OP_LD:  alu_res = arg2;
            OP_RSH: begin
                alu_res   = arg2 >> 1;
                alu_carry = arg2[0];
            end
            OP_RSC: begin
                alu_res   = (arg2 >> 1) | (carry_in ? top_one : '0);
                alu_carry = arg2[0];
            end
            OP_LSH: begin
                alu_res   = (arg2 << 1) & fmask;
                alu_carry = msb2;
            end
            OP_LSC: begin
                alu_res   = ((arg2 << 1) & fmask) | W'(carry_in);
                alu_carry = msb2;
            end
            OP_ASR: alu_res = (arg2 >> 1) | (msb2 ? top_one : '0);
            default: ;
        endcase
        wb_now = write_back(in1, alu_res, op_offset1, op_size, sign_extend);
    end

`ifdef WIDE_ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL_RUN} state_t;

    state_t           state;
    logic [W-1:0]     m;
    logic [W-1:0]     a;
    logic [W-1:0]     acc;
    logic [W-1:0]     acc_nxt;
    logic [W-1:0]     cap_in1;
    logic [W-1:0]     cap_mask;
    logic [SEL_W-1:0] cap_off;
    logic [SEL_W-1:0] cap_size;
    logic             cap_se;
    logic             cap_cin;
    logic [W:0]       wb_mul;

    always_comb begin
        acc_nxt = m[0] ? ((acc + a) & cap_mask) : acc;
        wb_mul  = write_back(cap_in1, acc_nxt, cap_off, cap_size, cap_se);
    end

    assign ready = (state == S_IDLE);

    // Control and result registers; multiply consumes one multiplier bit per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            res      <= '0;
            carry    <= 1'b0;
            zero     <= 1'b1;
            done     <= 1'b0;
            m        <= '0;
            a        <= '0;
            acc      <= '0;
            cap_in1  <= '0;
            cap_mask <= '0;
            cap_off  <= '0;
            cap_size <= '0;
            cap_se   <= 1'b0;
            cap_cin  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (operation == OP_MUL && arg1 != '0) begin
                            m        <= arg1;
                            a        <= arg2;
                            acc      <= '0;
                            cap_in1  <= in1;
                            cap_mask <= fmask;
                            cap_off  <= op_offset1;
                            cap_size <= op_size;
                            cap_se   <= sign_extend;
                            cap_cin  <= carry_in;
                            state    <= S_MUL_RUN;
                        end else begin
                            {zero, res} <= wb_now;
                            carry       <= alu_carry;
                            done        <= 1'b1;
                        end
                    end
                end
                S_MUL_RUN: begin
                    acc <= acc_nxt;
                    m   <= m >> 1;
                    a   <= (a << 1) & cap_mask;
                    if ((m >> 1) == '0) begin
                        {zero, res} <= wb_mul;
                        carry       <= cap_cin;
                        done        <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    assign ready = 1'b1;

    // Every accepted start completes at its own edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            res   <= '0;
            carry <= 1'b0;
            zero  <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                {zero, res} <= wb_now;
                carry       <= alu_carry;
                done        <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wide_alu_seq.sv
// Self-checking bench for wide_alu_seq (BLOCK_W=16, BLOCKS=4): directed cases plus random ops against a block-level model.
module tb_wide_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  operation;
    logic [63:0] in1;
    logic [63:0] in2;
    logic        carry_in;
    logic [1:0]  op_size;
    logic [1:0]  op_offset1;
    logic [1:0]  op_offset2;
    logic        sign_extend;
    logic [63:0] res;
    logic        carry;
    logic        zero;
    logic        ready;
    logic        done;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    wide_alu_seq #(.BLOCK_W(16), .BLOCKS(4), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .operation(operation),
        .in1(in1), .in2(in2), .carry_in(carry_in), .op_size(op_size),
        .op_offset1(op_offset1), .op_offset2(op_offset2), .sign_extend(sign_extend),
        .res(res), .carry(carry), .zero(zero), .ready(ready), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: field arithmetic on plain integers, write-back block by block.
    function automatic void model(input logic [3:0] op, input logic [63:0] i1, input logic [63:0] i2,
                                  input logic ci, input logic [1:0] sz, input logic [1:0] o1,
                                  input logic [1:0] o2, input logic se,
                                  output logic [63:0] r, output logic c, output logic z, output int lat);
        int          fw;
        int          hb;
        logic [64:0] m65;
        logic [64:0] sum;
        logic [63:0] mask, a1, a2, b, rf, top;
        logic        msb;
        fw  = (int'(sz) + 1) * 16;
        m65 = (65'd1 << fw) - 65'd1;
        mask = m65[63:0];
        a1  = (i1 >> (int'(o1) * 16)) & mask;
        a2  = (i2 >> (int'(o2) * 16)) & mask;
        top = 64'd1 << (fw - 1);
        c   = ci;
        lat = 1;
        rf  = a1;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                b   = (op == 4'd1 || op == 4'd3) ? (~a2 & mask) : a2;
                sum = {1'b0, a1} + {1'b0, b} + ((op == 4'd1) ? 65'd1 : (op == 4'd0) ? 65'd0 : {64'd0, ci});
                rf  = sum[63:0] & mask;
                c   = ((sum >> fw) & 65'd1) != 65'd0;
            end
            4'd4: rf = a1 & a2;
            4'd5: rf = a1 | a2;
            4'd6: rf = a1 ^ a2;
            4'd7: rf = a2;
`ifdef WIDE_ALU_MUL_EN
            4'd8: begin
                rf = (a1 * a2) & mask;
                if (a1 != 64'd0) begin
                    hb = 0;
                    for (int k = 0; k < 64; k++) if (a1[k]) hb = k;
                    lat = hb + 2;
                end
            end
`endif
            4'd9:  begin rf = a2 >> 1; c = a2[0]; end
            4'd10: begin rf = (a2 << 1) & mask; c = (a2 & top) != 64'd0; end
            4'd11: rf = (a2 >> 1) | (a2 & top);
            4'd12: begin rf = ((a2 << 1) & mask) | {63'd0, ci}; c = (a2 & top) != 64'd0; end
            4'd13: begin rf = (a2 >> 1) | (ci ? top : 64'd0); c = a2[0]; end
            default: rf = a1;
        endcase
        msb = (rf & top) != 64'd0;
        r = i1;
        z = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(o1) && k <= int'(o1) + int'(sz)) begin
                r[k*16 +: 16] = rf[(k - int'(o1))*16 +: 16];
                if (r[k*16 +: 16] != 16'd0) z = 1'b0;
            end else if (se && k > int'(o1) + int'(sz)) begin
                r[k*16 +: 16] = {16{msb}};
            end
        end
    endfunction

    // One op: start for a cycle, scramble inputs afterwards, wait for done with a cycle budget.
    task automatic do_op(input logic [3:0] op, input logic [63:0] i1, input logic [63:0] i2,
                         input logic ci, input logic [1:0] sz, input logic [1:0] o1,
                         input logic [1:0] o2, input logic se);
        logic [63:0] er;
        logic        ec, ez;
        int          el, n;
        model(op, i1, i2, ci, sz, o1, o2, se, er, ec, ez, el);
        @(negedge clk);
        operation = op; in1 = i1; in2 = i2; carry_in = ci;
        op_size = sz; op_offset1 = o1; op_offset2 = o2; sign_extend = se; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom};
        operation = 4'($urandom_range(0, 15)); carry_in = ~ci; sign_extend = ~se;
        n = 1;
        if (el > 1) chk("ready_busy", 64'(ready), 64'd0);
        while (done !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(el));
        chk("res", res, er);
        chk("carry", 64'(carry), 64'(ec));
        chk("zero", 64'(zero), 64'(ez));
        chk("ready_done", 64'(ready), 64'd1);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
        chk("hold_res", res, er);
    endtask

    initial begin
        logic [63:0] er, pr;
        logic        ec, ez, pc, pz;
        int          el, seen;
        logic [3:0]  op;
        int          r;

        rst = 1'b1; start = 1'b0; operation = '0; in1 = '0; in2 = '0; carry_in = 1'b0;
        op_size = '0; op_offset1 = '0; op_offset2 = '0; sign_extend = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_res", res, 64'd0);
        chk("rst_carry", 64'(carry), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;

        do_op(4'd0, 64'h0000_0000_FFFF_0000, 64'h1, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0);
        chk("add_res_const", res, 64'd0);
        do_op(4'd1, 64'h5, 64'h7, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
        chk("sub_res_const", res, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(4'd8, 64'h5, 64'h3, 1'b1, 2'd1, 2'd0, 2'd0, 1'b0);
        do_op(4'd8, 64'hAAAA_0000_0000_0000, 64'h1234, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0);
        do_op(4'd12, 64'h0, 64'h8000_0000_0000_0000, 1'b1, 2'd3, 2'd0, 2'd0, 1'b0);
        chk("lsc_res_const", res, 64'h1);
        do_op(4'd11, 64'h0, 64'h0000_0000_8000_0010, 1'b0, 2'd1, 2'd3, 2'd0, 1'b1);
        do_op(4'd15, 64'h1111_2222_3333_4444, 64'h0, 1'b1, 2'd2, 2'd1, 2'd0, 1'b0);

        // Reset during a multiply discards it; a start during the run is ignored.
        do_op(4'd7, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        operation = 4'd8; in1 = 64'hFFFF; in2 = 64'h2; carry_in = 1'b1;
        op_size = 2'd0; op_offset1 = 2'd0; op_offset2 = 2'd0; sign_extend = 1'b0; start = 1'b1;
        @(negedge clk);
        operation = 4'd7;
`ifdef WIDE_ALU_MUL_EN
        chk("mul_run_ready", 64'(ready), 64'd0);
`endif
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 64'(ready), 64'd1);
        chk("midrst_res", res, 64'd0);
        chk("midrst_zero", 64'(zero), 64'd1);
        chk("midrst_carry", 64'(carry), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("no_done_after_rst", 64'(seen), 64'd0);

        // Back-to-back single-cycle ops, one start per cycle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("b2b_done", 64'(done), 64'd1);
                chk("b2b_res", res, pr);
                chk("b2b_carry", 64'(carry), 64'(pc));
                chk("b2b_zero", 64'(zero), 64'(pz));
            end
            r  = int'($urandom_range(0, 14));
            op = (r >= 8) ? 4'(r + 1) : 4'(r);
            operation = op; in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom};
            carry_in = 1'($urandom); op_size = 2'($urandom); op_offset1 = 2'($urandom);
            op_offset2 = 2'($urandom); sign_extend = 1'($urandom); start = 1'b1;
            model(op, in1, in2, carry_in, op_size, op_offset1, op_offset2, sign_extend, pr, pc, pz, el);
        end
        @(negedge clk);
        start = 1'b0;
        chk("b2b_last_res", res, pr);
        chk("b2b_last_carry", 64'(carry), 64'(pc));

        for (int i = 0; i < 120; i++) begin
            do_op(4'($urandom_range(0, 15)), {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? 64'(16'($urandom)) : {$urandom, $urandom},
                  1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
